// File: rtl/lzc_pipe_norm.sv
// lzc_pipe_norm: two-stage pipelined leading-zero counter for the range-coder
// renormalisation path.
//
// Stage 1 registers one 3-bit leaf count plus an all-zero flag per input byte.
// Stage 2 merges the leaves with a balanced binary tree into the word-level
// count and all-zero flag. A valid/ready handshake lets both stages hold a
// word, so the pipe takes one word per cycle and absorbs back-pressure.
//
// Optional feature macro: LZC_NORM_EN
//   When defined, the input word rides along through stage 1 and stage 2
//   drives out_norm = in_data << out_count through a log2(WIDTH)-level barrel
//   shifter. When undefined, out_norm, the data register and the shifter are
//   absent; the count path is the same in both builds.
//
// Reset port 'reset' is asynchronous and active-low.

module lzc_pipe_norm #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH):0]   out_count,
    output logic                     out_zero,
    output logic [TAG_W-1:0]         out_tag
`ifdef LZC_NORM_EN
    ,
    output logic [WIDTH-1:0]         out_norm
`endif
);

    // Count width: encodes 0..WIDTH inclusive.
    localparam int CW  = $clog2(WIDTH) + 1;
    // Number of byte leaves.
    localparam int NB  = WIDTH / 8;
    // Merge tree depth and leaf count rounded up to a power of two.
    localparam int LV  = $clog2(NB);
    localparam int NBP = 1 << LV;
`ifdef LZC_NORM_EN
    // Barrel shifter depth.
    localparam int SH  = $clog2(WIDTH);
`endif

    // Leaf counter for one byte: {all_zero, leading_zero_count[2:0]}.
    // The count field is don't-care (left at 0) when the byte is zero.
    function automatic logic [3:0] leaf_lzc(input logic [7:0] b);
        logic [2:0] cnt;
        logic       found;
        cnt   = 3'd0;
        found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (!found && b[k]) begin
                cnt   = 3'(7 - k);
                found = 1'b1;
            end
        end
        return {~|b, cnt};
    endfunction

    // Balanced merge of the byte leaves, leaf 0 being the most significant
    // byte. Each node covers a contiguous run of bytes; when its upper half is
    // all zero the count is the upper half's bit width plus the lower half's
    // count. Missing leaves (WIDTH/8 not a power of two) are padded at the
    // low end as all-zero, so they never sit in front of a set bit.
    // Returns {all_zero, count}; an all-zero word reports count = WIDTH.
    function automatic logic [CW:0] merge_tree(
        input logic [NB*3-1:0] cnts,
        input logic [NB-1:0]   zeros
    );
        logic [CW-1:0] node_cnt  [NBP];
        logic          node_zero [NBP];
        logic [CW-1:0] total;
        for (int n = 0; n < NBP; n++) begin
            if (n < NB) begin
                node_cnt[n]  = CW'(cnts[3*n +: 3]);
                node_zero[n] = zeros[n];
            end else begin
                node_cnt[n]  = '0;
                node_zero[n] = 1'b1;
            end
        end
        // In-place reduction: node n at level l+1 is built from nodes 2n and
        // 2n+1 at level l. Writing index n never clobbers a later read because
        // every remaining read index is at least 2n+2.
        for (int l = 0; l < LV; l++) begin
            for (int n = 0; n < NBP / 2; n++) begin
                if (node_zero[2*n])
                    node_cnt[n] = CW'(8 << l) + node_cnt[2*n+1];
                else
                    node_cnt[n] = node_cnt[2*n];
                node_zero[n] = node_zero[2*n] & node_zero[2*n+1];
            end
        end
        total = node_zero[0] ? CW'(WIDTH) : node_cnt[0];
        return {node_zero[0], total};
    endfunction

`ifdef LZC_NORM_EN
    // Logarithmic left shifter filling with zeros. A shift of WIDTH only
    // happens for an all-zero word, which shifts to zero anyway.
    function automatic logic [WIDTH-1:0] barrel_shl(
        input logic [WIDTH-1:0] d,
        input logic [CW-1:0]    sh
    );
        logic [WIDTH-1:0] v;
        v = d;
        for (int k = 0; k < SH; k++) begin
            if (sh[k])
                v = v << (1 << k);
        end
        return v;
    endfunction
`endif

    // Stage 1 registers.
    logic                s1_valid;
    logic [NB*3-1:0]     s1_cnt;
    logic [NB-1:0]       s1_zero;
    logic [TAG_W-1:0]    s1_tag;
`ifdef LZC_NORM_EN
    logic [WIDTH-1:0]    s1_data;
`endif

    // Combinational leaf results and merge results.
    logic [NB*3-1:0]     leaf_cnt;
    logic [NB-1:0]       leaf_zero;
    logic [CW:0]         merged;
    logic [CW-1:0]       merged_cnt;
    logic                merged_zero;

    // Pipeline advance enables.
    logic                s2_adv;
    logic                s1_adv;

    // Handshake: a stage may load when it is empty or its content moves on.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid  || s2_adv;
        in_ready = s1_adv;
    end

    // Leaf level: byte i counted from the MSB feeds leaf i.
    always_comb begin
        leaf_cnt  = '0;
        leaf_zero = '0;
        for (int i = 0; i < NB; i++) begin
            {leaf_zero[i], leaf_cnt[3*i +: 3]} = leaf_lzc(in_data[WIDTH-1-8*i -: 8]);
        end
    end

    // Merge level: reduce the registered leaves to the word result.
    always_comb begin
        merged      = merge_tree(s1_cnt, s1_zero);
        merged_zero = merged[CW];
        merged_cnt  = merged[CW-1:0];
    end

    // Stage 1 register: capture leaf results whenever the stage can advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_cnt   <= '0;
            s1_zero  <= '0;
            s1_tag   <= '0;
`ifdef LZC_NORM_EN
            s1_data  <= '0;
`endif
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cnt  <= leaf_cnt;
                s1_zero <= leaf_zero;
                s1_tag  <= in_tag;
`ifdef LZC_NORM_EN
                s1_data <= in_data;
`endif
            end
        end
    end

    // Stage 2 register: publish the merged result and hold it under stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_zero  <= 1'b0;
            out_tag   <= '0;
`ifdef LZC_NORM_EN
            out_norm  <= '0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_count <= merged_cnt;
                out_zero  <= merged_zero;
                out_tag   <= s1_tag;
`ifdef LZC_NORM_EN
                out_norm  <= merged_zero ? '0 : barrel_shl(s1_data, merged_cnt);
`endif
            end
        end
    end

endmodule

// File: tb/tb_lzc_pipe_norm.sv
// tb_lzc_pipe_norm: self-checking bench for lzc_pipe_norm at WIDTH=16,
// TAG_W=8. Directed words, back-to-back streaming, back-pressure, random
// handshake toggling and mid-flight reset are driven from one initial block.
// Expected results come from a bit-serial reference model and a queue
// scoreboard. out_norm is checked only when LZC_NORM_EN is defined.

module tb_lzc_pipe_norm;

    localparam int WIDTH = 16;
    localparam int TAG_W = 8;
    localparam int CW    = $clog2(WIDTH) + 1;

    typedef struct {
        logic [CW-1:0]    cnt;
        logic             zero;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] norm;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;
`ifdef LZC_NORM_EN
    logic [WIDTH-1:0] out_norm;
`endif

    int   checks;
    int   passed;
    int   accepted;
    int   received;
    exp_t sb[$];

    lzc_pipe_norm #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
`ifdef LZC_NORM_EN
        ,
        .out_norm  (out_norm)
`endif
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shift the word left one bit at a time until its MSB is set.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t);
        exp_t             e;
        int               n;
        logic [WIDTH-1:0] v;
        n = 0;
        v = d;
        while (n < WIDTH && v[WIDTH-1] == 1'b0) begin
            v = v << 1;
            n++;
        end
        e.cnt  = CW'(n);
        e.zero = (d == '0);
        e.tag  = t;
        e.norm = v;
        return e;
    endfunction

    // Random word with a random number of leading zeros.
    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        w = WIDTH'($urandom);
        w = w >> $urandom_range(0, WIDTH);
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic [TAG_W-1:0] t, input logic r);
        in_valid  = v;
        in_data   = d;
        in_tag    = t;
        out_ready = r;
    endtask

    // Mid-cycle handshake bookkeeping: score a drained result, queue an accepted word.
    task automatic observe();
        exp_t e;
        if (out_valid === 1'b1 && out_ready) begin
            checkOutput("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("sb_count", 32'(out_count), 32'(e.cnt));
                checkOutput("sb_zero",  32'(out_zero),  32'(e.zero));
                checkOutput("sb_tag",   32'(out_tag),   32'(e.tag));
`ifdef LZC_NORM_EN
                checkOutput("sb_norm",  32'(out_norm),  32'(e.norm));
`endif
                received++;
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            sb.push_back(model(in_data, in_tag));
            accepted++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    // Drain with in_valid low until the scoreboard empties, bounded.
    task automatic drain(input string name);
        applyStimulus(1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 20 && sb.size() > 0; k++) cyc();
        checkOutput(name, 32'(sb.size()), 32'd0);
    endtask

    // One isolated word with exact latency and directed expected values.
    task automatic single_word(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t,
                               input int ec, input logic ez, input logic [WIDTH-1:0] en);
        applyStimulus(1'b1, d, t, 1'b1);
        @(negedge clk);
        checkOutput("single_in_ready", 32'(in_ready), 32'd1);
        observe();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("single_not_yet_valid", 32'(out_valid), 32'd0);
        observe();
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_count", 32'(out_count), 32'(ec));
        checkOutput("single_zero",  32'(out_zero),  32'(ez));
        checkOutput("single_tag",   32'(out_tag),   32'(t));
`ifdef LZC_NORM_EN
        checkOutput("single_norm",  32'(out_norm),  32'(en));
`else
        if (en != '0) begin end
`endif
        observe();
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("single_drained", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rec0;
        int acc0;
        checks   = 0;
        passed   = 0;
        accepted = 0;
        received = 0;
        reset    = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_count", 32'(out_count), 32'd0);
        checkOutput("rst_out_zero",  32'(out_zero),  32'd0);
        checkOutput("rst_out_tag",   32'(out_tag),   32'd0);
`ifdef LZC_NORM_EN
        checkOutput("rst_out_norm",  32'(out_norm),  32'd0);
`endif
        reset = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed single words.
        $display("[TB] directed single words");
        single_word(16'h8000, 8'h11, 0,  1'b0, 16'h8000);
        single_word(16'h0001, 8'h22, 15, 1'b0, 16'h8000);
        single_word(16'h00FF, 8'h33, 8,  1'b0, 16'hFF00);
        single_word(16'h0000, 8'h44, 16, 1'b1, 16'h0000);
        single_word(16'h0123, 8'h5A, 7,  1'b0, 16'h9180);

        // Back-to-back streaming.
        $display("[TB] back-to-back stream");
        rec0 = received;
        for (int c = 0; c < 64; c++) begin
            applyStimulus(1'b1, rand_word(), TAG_W'($urandom), 1'b1);
            @(negedge clk);
            checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
            if (c >= 2) checkOutput("b2b_out_valid", 32'(out_valid), 32'd1);
            observe();
            @(posedge clk);
            #1;
        end
        drain("b2b_drained");
        checkOutput("b2b_results", 32'(received - rec0), 32'd64);

        // Back-pressure: two words fill the pipe, then in_ready drops.
        $display("[TB] back-pressure");
        acc0 = accepted;
        rec0 = received;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, rand_word(), TAG_W'($urandom), 1'b0);
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'(c < 2));
            if (c >= 2) begin
                checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
                checkOutput("bp_hold_count", 32'(out_count), 32'(sb[0].cnt));
                checkOutput("bp_hold_tag",   32'(out_tag),   32'(sb[0].tag));
            end
            observe();
            @(posedge clk);
            #1;
        end
        checkOutput("bp_accepted", 32'(accepted - acc0), 32'd2);
        drain("bp_drained");
        checkOutput("bp_results", 32'(received - rec0), 32'd2);
        @(negedge clk);
        checkOutput("bp_idle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Random handshake toggling.
        $display("[TB] random handshake");
        acc0 = accepted;
        rec0 = received;
        for (int c = 0; c < 8000 && (accepted - acc0) < 1000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_word(), TAG_W'($urandom),
                          $urandom_range(0, 2) != 0);
            cyc();
        end
        checkOutput("rnd_accepted", 32'(accepted - acc0), 32'd1000);
        drain("rnd_drained");
        checkOutput("rnd_results", 32'(received - rec0), 32'd1000);

        // Reset with both stages full.
        $display("[TB] reset while full");
        applyStimulus(1'b1, 16'h0F00, 8'hA1, 1'b0);
        cyc();
        applyStimulus(1'b1, 16'h0030, 8'hA2, 1'b0);
        cyc();
        applyStimulus(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checkOutput("full_out_valid", 32'(out_valid), 32'd1);
        checkOutput("full_in_ready",  32'(in_ready),  32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("mid_rst_out_tag",   32'(out_tag),   32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, '0, '0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("post_rst_no_stale", 32'(out_valid), 32'd0);
            checkOutput("post_rst_in_ready", 32'(in_ready),  32'd1);
            observe();
            @(posedge clk);
            #1;
        end
        single_word(16'h0040, 8'hC3, 9, 1'b0, 16'h8000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
